// File: rtl/latency_pkg.sv
// Shared definitions for the programmable-latency delay line.
//   ST_RUN / ST_DRAIN : FSM state encodings (legacy-compatible localparams)
//   clog2             : ceiling log2 for sizing latency/occupancy fields
//   clamp_lat         : saturates a requested latency at the physical depth
package latency_pkg;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    function automatic int clog2(input int value);
        int result;
        int x;
        result = 0;
        x      = value - 1;
        while (x > 0) begin
            result = result + 1;
            x      = x >> 1;
        end
        return result;
    endfunction

    function automatic int clamp_lat(input int sel, input int max_lat);
        return (sel > max_lat) ? max_lat : sel;
    endfunction

endpackage

// File: rtl/latency_pipe_if.sv
// Handshake, control and status bundle for latency_pipe.
//   master : drives in_valid/in_data, stall, flush, lat_sel/lat_load
//   slave  : drives in_ready, out_valid/out_data, lat_cur, busy, occupancy
interface latency_pipe_if #(
    parameter int WIDTH = 8,
    parameter int LAT_W = 4
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             stall;
    logic             flush;
    logic [LAT_W-1:0] lat_sel;
    logic             lat_load;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [LAT_W-1:0] lat_cur;
    logic             busy;
    logic [LAT_W-1:0] occupancy;

    modport master (
        output in_valid, in_data, stall, flush, lat_sel, lat_load,
        input  in_ready, out_valid, out_data, lat_cur, busy, occupancy
    );

    modport slave (
        input  in_valid, in_data, stall, flush, lat_sel, lat_load,
        output in_ready, out_valid, out_data, lat_cur, busy, occupancy
    );
endinterface

// File: rtl/latency_pipe_stage.sv
// One register stage of the delay line: payload plus valid bit.
//   clk, reset : clock, asynchronous active-high reset
//   i_en       : advance (low while stalled)
//   i_clr      : synchronous clear of the valid bit, wins over i_en
//   i_kill     : stage lies beyond the active latency; incoming valid dropped
//   i_valid/i_data -> o_valid/o_data
module pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic             i_kill,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);
    logic             r_valid;
    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_clr) begin
            r_valid <= 1'b0;
        end else if (i_en) begin
            r_valid <= i_valid & ~i_kill;
            r_data  <= i_data;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
endmodule

// File: rtl/latency_pipe.sv
// Runtime-programmable delay line (0..MAX_LATENCY) with stall and flush.
// A latency change while items are in flight first drains the pipe so no
// item ever leaves with a mixed delay.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : latency_pipe_if.slave (data handshake, control, status)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RUN   | accepting input; latency loads apply at once if pipe empties
// ST_DRAIN | input blocked; shifting out old items, pending latency held
module latency_pipe
    import latency_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int MAX_LATENCY     = 8,
    parameter int DEFAULT_LATENCY = 1
) (
    input logic           clk,
    input logic           reset,
    latency_pipe_if.slave bus
);
    localparam int LAT_W = clog2(MAX_LATENCY + 1);

    logic [0:0]             r_state;
    logic [LAT_W-1:0]       r_lat;
    logic [LAT_W-1:0]       r_pend;
    logic [LAT_W-1:0]       r_occ;

    logic [LAT_W-1:0]       w_req;
    logic [LAT_W-1:0]       w_pend_eff;
    logic [LAT_W-1:0]       w_occ_nxt;
    logic                   w_ready;
    logic                   w_acc;
    logic                   w_inc;
    logic                   w_tap_vld;
    logic [WIDTH-1:0]       w_tap_data;
    logic [MAX_LATENCY-1:0] w_vld;
    logic [MAX_LATENCY-1:0] w_sin_vld;
    logic [MAX_LATENCY-1:0] w_kill;
    logic [WIDTH-1:0]       w_data     [MAX_LATENCY];
    logic [WIDTH-1:0]       w_sin_data [MAX_LATENCY];

    assign w_ready = (r_state == ST_RUN) & ~bus.stall;
    assign w_acc   = bus.in_valid & w_ready;
    assign w_req   = LAT_W'(clamp_lat(int'(bus.lat_sel), MAX_LATENCY));

    for (genvar g = 0; g < MAX_LATENCY; g++) begin : g_stage
        if (g == 0) begin : g_head
            assign w_sin_vld[g]  = w_acc;
            assign w_sin_data[g] = bus.in_data;
        end else begin : g_body
            assign w_sin_vld[g]  = w_vld[g-1];
            assign w_sin_data[g] = w_data[g-1];
        end

        // Stages at or beyond the active latency never hold a valid item.
        assign w_kill[g] = (LAT_W'(g) >= r_lat);

        pipe_stage #(.WIDTH(WIDTH)) u_stage (
            .clk     (clk),
            .reset   (reset),
            .i_en    (~bus.stall),
            .i_clr   (bus.flush),
            .i_kill  (w_kill[g]),
            .i_valid (w_sin_vld[g]),
            .i_data  (w_sin_data[g]),
            .o_valid (w_vld[g]),
            .o_data  (w_data[g])
        );
    end

    // Output tap is stage lat_cur-1; lat_cur==0 matches nothing here.
    always_comb begin
        w_tap_vld  = 1'b0;
        w_tap_data = '0;
        for (int i = 0; i < MAX_LATENCY; i++) begin
            if (r_lat == LAT_W'(i + 1)) begin
                w_tap_vld  = w_vld[i];
                w_tap_data = w_data[i];
            end
        end
    end

    // Occupancy tracks entries into stage 0 and exits from the tap.
    assign w_inc = w_acc & (r_lat != '0);

    always_comb begin
        if (bus.flush) begin
            w_occ_nxt = '0;
        end else if (bus.stall) begin
            w_occ_nxt = r_occ;
        end else begin
            w_occ_nxt = r_occ + LAT_W'(w_inc) - LAT_W'(w_tap_vld);
        end
    end

    // A load during DRAIN replaces the pending value, even on the exit edge.
    assign w_pend_eff = bus.lat_load ? w_req : r_pend;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_lat   <= LAT_W'(DEFAULT_LATENCY);
            r_pend  <= '0;
            r_occ   <= '0;
        end else begin
            r_occ <= w_occ_nxt;
            if (r_state == ST_RUN) begin
                if (bus.lat_load && (w_req != r_lat)) begin
                    if (w_occ_nxt == '0) begin
                        r_lat <= w_req;
                    end else begin
                        r_pend  <= w_req;
                        r_state <= ST_DRAIN;
                    end
                end
            end else begin
                if (w_occ_nxt == '0) begin
                    r_lat   <= w_pend_eff;
                    r_state <= ST_RUN;
                end else begin
                    r_pend <= w_pend_eff;
                end
            end
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.out_valid = (r_lat == '0) ? w_acc : w_tap_vld;
    assign bus.out_data  = (r_lat == '0) ? (w_acc ? bus.in_data : '0)
                                         : (w_tap_vld ? w_tap_data : '0);
    assign bus.lat_cur   = r_lat;
    assign bus.busy      = (r_state == ST_DRAIN);
    assign bus.occupancy = r_occ;
endmodule

// File: tb/tb_latency_pipe.sv
module tb_latency_pipe;
    localparam int WIDTH   = 8;
    localparam int MAX_LAT = 8;
    localparam int LAT_W   = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    latency_pipe_if #(.WIDTH(WIDTH), .LAT_W(LAT_W)) bus ();

    latency_pipe #(
        .WIDTH           (WIDTH),
        .MAX_LATENCY     (MAX_LAT),
        .DEFAULT_LATENCY (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] data;
        int         due;
    } ent_t;

    ent_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   tick    = 0;   // count of unstalled edges
    int   m_lat   = 1;
    int   m_pend  = 0;
    bit   m_busy  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at posedge+1, check at negedge, update model.
    task automatic cyc(input bit v, input int d, input bit st, input bit fl,
                       input bit ld, input int sel);
        bit         rdy;
        bit         acc;
        bit         ov;
        int         req;
        int         occ_n;
        logic [7:0] od;
        bus.in_valid = v;
        bus.in_data  = 8'(d);
        bus.stall    = st;
        bus.flush    = fl;
        bus.lat_load = ld;
        bus.lat_sel  = 4'(sel);
        @(negedge clk);
        rdy = !m_busy && !st;
        chk("lat_cur",   32'(bus.lat_cur),   32'(m_lat));
        chk("busy",      32'(bus.busy),      32'(m_busy));
        chk("in_ready",  32'(bus.in_ready),  32'(rdy));
        chk("occupancy", 32'(bus.occupancy), 32'(q.size()));
        acc = v && rdy;
        if (acc) q.push_back('{data: 8'(d), due: tick + m_lat});
        ov = (q.size() > 0) && (q[0].due == tick);
        od = ov ? q[0].data : 8'h00;
        chk("out_valid", 32'(bus.out_valid), 32'(ov));
        chk("out_data",  32'(bus.out_data),  32'(od));
        if (ov && !st && !fl) void'(q.pop_front());
        if (fl) q.delete();
        occ_n = q.size();
        req = (sel > MAX_LAT) ? MAX_LAT : sel;
        if (!m_busy) begin
            if (ld && (req != m_lat)) begin
                if (occ_n == 0) m_lat = req;
                else begin
                    m_pend = req;
                    m_busy = 1'b1;
                end
            end
        end else begin
            if (ld) m_pend = req;
            if (occ_n == 0) begin
                m_lat  = m_pend;
                m_busy = 1'b0;
            end
        end
        if (!st) tick++;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d);
        cyc(1'b1, d, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.stall    = 1'b0;
        bus.flush    = 1'b0;
        bus.lat_load = 1'b0;
        bus.lat_sel  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_lat_cur",   32'(bus.lat_cur),   32'd1);
        chk("rst_busy",      32'(bus.busy),      32'd0);
        chk("rst_occupancy", 32'(bus.occupancy), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data",  32'(bus.out_data),  32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 1: default latency 1, continuous stream; same-value load is a no-op
        for (int i = 1; i <= 10; i++) begin
            if (i == 5) cyc(1'b1, i, 1'b0, 1'b0, 1'b1, 1);
            else        send(i);
        end
        idle(3);

        // 2: load 4 while idle, single item
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, 4);
        send(8'hA5);
        idle(6);

        // 3: shrink to 2 mid-stream -> drain
        for (int i = 0; i < 6; i++) send(8'h20 + i);
        cyc(1'b1, 8'h26, 1'b0, 1'b0, 1'b1, 2);
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 0);
        idle(6);
        send(8'h33);
        idle(4);

        // 4: latency 3 with a 5-cycle stall mid-stream
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, 3);
        for (int i = 0; i < 3; i++) send(8'h40 + i);
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'h99, 1'b1, 1'b0, 1'b0, 0);
        send(8'h43);
        send(8'h44);
        idle(5);

        // 5: flush in RUN, flush in DRAIN, flush together with load
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, 4);
        for (int i = 0; i < 3; i++) send(8'h50 + i);
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b0, 0);
        idle(5);
        for (int i = 0; i < 3; i++) send(8'h60 + i);
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, 6);
        idle(1);
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b0, 0);
        send(8'h70);
        idle(7);
        send(8'h80);
        send(8'h81);
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b1, 2);
        send(8'h82);
        idle(3);

        // 6: passthrough, clamp, reset during drain
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, 0);
        for (int i = 0; i < 4; i++) send(8'h90 + i);
        cyc(1'b1, 8'h9F, 1'b1, 1'b0, 1'b0, 0);
        send(8'h94);
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, 15);
        for (int i = 0; i < 3; i++) send(8'hB0 + i);
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, 2);
        idle(2);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_lat_cur",   32'(bus.lat_cur),   32'd1);
        chk("mid_rst_busy",      32'(bus.busy),      32'd0);
        chk("mid_rst_occupancy", 32'(bus.occupancy), 32'd0);
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        q.delete();
        m_lat  = 1;
        m_busy = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        send(8'hC1);
        send(8'hC2);
        idle(3);

        chk("scoreboard_empty", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/latency_pipe.md
Name: latency_pipe

Overview:
- Runtime-programmable delay line for one data channel with a qualifying valid bit, stall support and flush support.
- Latency is selectable at run time from 0 to MAX_LATENCY.
- When latency changes, the block first drains in-flight data, so no item is ever emitted with a mixed delay.
- Sits between NN datapath stages (MAC array, activation, writeback) to align operands and control whose relative latency depends on layer configuration.

Parameters:
WIDTH, 8, data bit width
MAX_LATENCY, 8, number of physical stages; upper bound on programmable latency (>=1)
DEFAULT_LATENCY, 1, latency in effect after reset (0..MAX_LATENCY)
LAT_W, clog2(MAX_LATENCY+1), localparam; width of latency and occupancy fields

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_valid  input  1  input item present
in_data  input  WIDTH  input payload
in_ready  output  1  item accepted this cycle when in_valid & in_ready
stall  input  1  freeze all stages
flush  input  1  discard all in-flight items
lat_sel  input  LAT_W  requested latency
lat_load  input  1  one-cycle strobe: request latency = lat_sel
out_valid  output  1  delayed item present
out_data  output  WIDTH  delayed payload; 0 when out_valid=0
lat_cur  output  LAT_W  latency currently in effect
busy  output  1  latency change pending (DRAIN state)
occupancy  output  LAT_W  valid items in stages 0..lat_cur-1

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- On reset:
  - all stage data and valid bits = 0
  - lat_cur = DEFAULT_LATENCY
  - state = RUN
  - busy = 0, occupancy = 0, out_valid = 0, out_data = 0
- Reset asserted mid-operation discards everything immediately, including any pending latency.
- in_ready = (state==RUN) & !stall. In DRAIN or during stall, in_valid items are dropped and never emitted.
- Shift (stall=0, flush=0), per edge:
  - stage[0] <= {in_valid&in_ready, in_data}
  - stage[i] <= stage[i-1]
  - valid into any stage index >= lat_cur is forced to 0.
- stall=1: all stages hold. out_valid/out_data stay presented unchanged, with no duplicate emission counted downstream.
- flush=1: all valid bits cleared at the edge. Flush has priority over stall and shift. The input in that cycle is dropped.
- Output:
  - lat_cur>=1: out = stage[lat_cur-1], masked to 0 when its valid bit is 0.
  - lat_cur=0: combinational passthrough; out_valid = in_valid & in_ready, out_data = in_data masked; occupancy = 0.
- Latency = exactly lat_cur accepted-and-unstalled clock edges; stalled edges do not count.
- lat_sel > MAX_LATENCY is clamped to MAX_LATENCY.
- State machine RUN/DRAIN:
  - RUN, lat_load with clamped lat_sel == lat_cur: no-op.
  - RUN, lat_load with a new value, occupancy==0 (after this edge): lat_cur updates at that edge; stay in RUN.
  - RUN, lat_load with a new value, occupancy>0: latch pending value; go to DRAIN (busy=1).
  - DRAIN: stages keep shifting (subject to stall) until occupancy==0. At that edge lat_cur <= pending and state goes to RUN. The first new input is accepted the following cycle.
  - lat_load during DRAIN: overwrites the pending value.
  - flush during DRAIN: occupancy becomes 0, so pending is applied at the same edge.
  - flush and lat_load in the same cycle: the new latency is applied at that edge; state = RUN.
- occupancy is updated every edge and never exceeds lat_cur.

Decomposition:
- Package latency_pkg:
  - state encoding (ST_RUN, ST_DRAIN)
  - clog2 constant function
  - latency clamp function
- Sub-module pipe_stage: one register stage with valid, enable (!stall), sync clear (flush) and kill (index>=lat_cur); instantiated MAX_LATENCY times via generate.
- The FSM, occupancy counter and output mux live in the top level.

Test Plan:
1. Reset, lat 1 default, stream in_data 1..10 every cycle -> out_data 1..10 one cycle later; occupancy steady at 1.
2. lat_load lat_sel=4 while idle -> lat_cur=4 next edge, busy never set; item 0xA5 appears exactly 4 edges after acceptance.
3. Stream at lat 4, lat_load lat_sel=2 mid-stream -> busy=1, in_ready=0; remaining 4 items emitted unchanged; lat_cur=2 when occupancy hits 0; the next item exits after 2 edges.
4. lat 3, stall for 5 cycles mid-stream -> output held, no items lost or duplicated; total delay per item = 3 + stalled cycles.
5. lat 4 with 3 items in flight, flush -> out_valid=0 next cycle, occupancy=0, flushed items never appear; flush during DRAIN applies pending latency that edge.
6. lat_sel=0 -> passthrough, out equals input same cycle; lat_sel=15 with MAX_LATENCY=8 -> lat_cur=8; reset asserted in DRAIN -> lat_cur=DEFAULT_LATENCY, busy=0.
